spi_slave_responder: RTL

SPI responder (slave) that terminates the serial link driven by the team's SPI master: it receives MOSI words and returns MISO words on the same SCLK/CS pins. All SPI inputs are oversampled and synchronised into the single GCLK domain; no logic runs on SCLK. It is the reference end-point for master bring-up and for loop-back benches, and it is built for synthesis.

---
 rtl/spi_pkg.sv | 48 ++++
 rtl/spi_sync_edge.sv | 61 ++++++
 rtl/spi_slave_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// +----------------------------------------------------------------------+
// | spi_pkg : shared types and helpers for the SPI responder             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package spi_pkg;

  localparam int c_DATA_W = 32;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic [1:0] {
    WL_8  = 2'b00,
    WL_16 = 2'b01,
    WL_24 = 2'b10,
    WL_32 = 2'b11
  } word_len_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  function automatic logic [5:0] word_bits(input word_len_t len);
    case (len)
      WL_8:    return 6'd8;
      WL_16:   return 6'd16;
      WL_24:   return 6'd24;
      default: return 6'd32;
    endcase
  endfunction

  function automatic logic [c_DATA_W-1:0] word_mask(input word_len_t len);
    case (len)
      WL_8:    return 32'h0000_00FF;
      WL_16:   return 32'h0000_FFFF;
      WL_24:   return 32'h00FF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// +----------------------------------------------------------------------+
// | spi_sync_edge : multi-flop synchroniser with registered edge pulses  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module spi_sync_edge #(
  parameter int STAGES      = 2,
  parameter bit RESET_VAL   = 1'b0,
  parameter bit EDGE_DETECT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign level_o = sync_q[STAGES-1];

  generate
    if (EDGE_DETECT) begin : g_edge
      logic prev_q;
      logic rise_q;
      logic fall_q;

      // Pulses are registered so an edge appears STAGES+1 clocks after the pin.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prev_q <= RESET_VAL;
          rise_q <= 1'b0;
          fall_q <= 1'b0;
        end else begin
          prev_q <= level_o;
          rise_q <= level_o & ~prev_q;
          fall_q <= ~level_o & prev_q;
        end
      end

      assign rise_o = rise_q;
      assign fall_o = fall_q;
    end else begin : g_no_edge
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/spi_slave_responder.sv
// +----------------------------------------------------------------------+
// | spi_slave_responder : oversampled SPI slave, 8/16/24/32-bit words    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module spi_slave_responder
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        GCLK,
  input  logic        RST,
  input  logic [1:0]  spi_mode_in,
  input  logic [1:0]  word_len_in,
  input  logic [31:0] miso_data_in,
  input  logic        SCLK_in,
  input  logic        CS_in,
  input  logic        MOSI_in,
  output logic        MISO_out,
  output logic [31:0] mosi_data_out,
  output logic        rx_valid_out,
  output logic        tx_load_out,
  output logic        busy_out,
  output logic        frame_err_out
);

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi;
  logic unused_sclk_lvl, unused_cs_lvl, unused_mosi_rise, unused_mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_DETECT(1'b1)) u_sync_sclk (
    .clk(GCLK), .rst(RST), .d_i(SCLK_in),
    .level_o(w_sclk_lvl), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
  );

  // CS chain resets low so a CS already held low out of reset never looks like a new frame.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_DETECT(1'b1)) u_sync_cs (
    .clk(GCLK), .rst(RST), .d_i(CS_in),
    .level_o(w_cs_lvl), .rise_o(w_cs_rise), .fall_o(w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .EDGE_DETECT(1'b0)) u_sync_mosi (
    .clk(GCLK), .rst(RST), .d_i(MOSI_in),
    .level_o(w_mosi), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
  );

  assign unused_sclk_lvl = w_sclk_lvl;
  assign unused_cs_lvl   = w_cs_lvl;

  state_t      state_q, state_d;
  spi_mode_t   mode_q, mode_d;
  word_len_t   len_q, len_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] tx_q, tx_d;
  logic        miso_q, miso_d;
  logic [31:0] mosi_data_q, mosi_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        tx_load_q, tx_load_d;
  logic        frame_err_q, frame_err_d;

  logic        w_lead, w_trail, w_sample, w_shift;
  logic [5:0]  w_nbits;
  logic [4:0]  w_msb, w_in_msb;
  logic [31:0] w_rx_next;
  word_len_t   w_len_in;
  spi_mode_t   w_mode_in;

  assign w_len_in  = word_len_t'(word_len_in);
  assign w_mode_in = spi_mode_t'(spi_mode_in);
  assign w_nbits   = word_bits(len_q);
  assign w_msb     = 5'(w_nbits - 6'd1);
  assign w_in_msb  = 5'(word_bits(w_len_in) - 6'd1);
  assign w_lead    = mode_q.cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail   = mode_q.cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample  = mode_q.cpha ? w_trail : w_lead;
  assign w_shift   = mode_q.cpha ? w_lead : w_trail;
  assign w_rx_next = {rx_q[30:0], w_mosi};

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    mosi_data_d = mosi_data_q;
    rx_valid_d  = 1'b0;
    tx_load_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_cs_fall) begin
          state_d   = ST_ACTIVE;
          mode_d    = w_mode_in;
          len_d     = w_len_in;
          cnt_d     = 6'd0;
          rx_d      = 32'd0;
          tx_load_d = 1'b1;
          // CPHA=0 must show the MSB before the first edge; CPHA=1 presents it on the first leading edge.
          if (!w_mode_in.cpha) begin
            miso_d = miso_data_in[w_in_msb];
            tx_d   = miso_data_in << 1;
          end else begin
            miso_d = 1'b0;
            tx_d   = miso_data_in;
          end
        end
      end
      ST_ACTIVE: begin
        if (w_cs_rise) begin
          state_d     = ST_IDLE;
          miso_d      = 1'b0;
          frame_err_d = (cnt_q != 6'd0);
        end else begin
          if (w_shift) begin
            miso_d = tx_q[w_msb];
            tx_d   = tx_q << 1;
          end
          if (w_sample) begin
            rx_d = w_rx_next;
            if (cnt_q == w_nbits - 6'd1) begin
              cnt_d       = 6'd0;
              mosi_data_d = w_rx_next & word_mask(len_q);
              rx_valid_d  = 1'b1;
              // Unshifted reload: the next shift edge presents the new MSB.
              tx_d        = miso_data_in;
              tx_load_d   = 1'b1;
            end else begin
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge GCLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      mode_q      <= '0;
      len_q       <= WL_8;
      cnt_q       <= 6'd0;
      rx_q        <= 32'd0;
      tx_q        <= 32'd0;
      miso_q      <= 1'b0;
      mosi_data_q <= 32'd0;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      mosi_data_q <= mosi_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_load_q   <= tx_load_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign MISO_out      = miso_q;
  assign mosi_data_out = mosi_data_q;
  assign rx_valid_out  = rx_valid_q;
  assign tx_load_out   = tx_load_q;
  assign busy_out      = (state_q == ST_ACTIVE);
  assign frame_err_out = frame_err_q;

endmodule

`default_nettype wire
